// File: rtl/wb_rr_data_arbiter.sv
// rtl/wb_rr_data_arbiter.sv - round-robin Wishbone data-port arbiter with bus watchdog
module wb_rr_data_arbiter #(
    parameter int N_MST   = 3,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_MST-1:0]      i_m_cyc,
    input  logic [N_MST-1:0]      i_m_we,
    input  logic [N_MST*AW-1:0]   i_m_adr,
    input  logic [N_MST*DW-1:0]   i_m_dat_w,
    output logic [DW-1:0]         o_m_dat_r,
    output logic [N_MST-1:0]      o_m_ack,
    output logic [N_MST-1:0]      o_m_err,
    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [AW-1:0]         o_s_adr,
    output logic [DW-1:0]         o_s_dat_w,
    input  logic [DW-1:0]         i_s_dat_r,
    input  logic                  i_s_ack,
    output logic [N_MST-1:0]      o_grant,
    output logic                  o_busy
);

    localparam int            IW      = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam bit            WD_EN   = (TIMEOUT > 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_MST-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]    r_last, w_last_nxt;
    logic [TW-1:0]    r_wdog, w_wdog_nxt;
    logic [IW-1:0]    w_gidx;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_try;
    logic             w_pick_vld;
    logic             w_busy;
    logic             w_act;
    logic             w_ack;
    logic             w_tmo;

    // Binary index of the registered one-hot grant.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (r_grant[i]) w_gidx = IW'(i);
        end
    end

    // Rotating-priority search starting just after the last served master.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_try      = '0;
        for (int k = 1; k <= N_MST; k++) begin
            w_try = IW'((int'(r_last) + k) % N_MST);
            if (!w_pick_vld && i_m_cyc[w_try]) begin
                w_pick     = w_try;
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_busy = (r_state == ST_BUSY);
    assign w_act  = w_busy & i_m_cyc[w_gidx];
    assign w_ack  = w_act & i_s_ack;
    // A simultaneous ack takes precedence over the watchdog firing.
    assign w_tmo  = WD_EN & w_act & ~i_s_ack & (r_wdog == TO_LAST);

    assign o_s_cyc   = w_act;
    assign o_s_stb   = w_act;
    assign o_s_we    = w_busy & i_m_we[w_gidx];
    assign o_s_adr   = w_busy ? i_m_adr[w_gidx*AW +: AW] : '0;
    assign o_s_dat_w = w_busy ? i_m_dat_w[w_gidx*DW +: DW] : '0;
    assign o_m_dat_r = w_busy ? i_s_dat_r : '0;
    assign o_m_ack   = w_ack ? r_grant : '0;
    assign o_m_err   = w_tmo ? r_grant : '0;
    assign o_grant   = r_grant;
    assign o_busy    = w_busy;

    // Next-state: grant in IDLE, release on ack, watchdog expiry or master abort.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_wdog_nxt  = r_wdog;
        case (r_state)
            ST_IDLE: begin
                w_wdog_nxt = '0;
                if (w_pick_vld) begin
                    w_grant_nxt = {{(N_MST-1){1'b0}}, 1'b1} << w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_act || w_ack || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_gidx;
                    w_wdog_nxt  = '0;
                end else if (WD_EN && (r_wdog != TO_LAST)) begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_wdog_nxt  = '0;
            end
        endcase
    end

    // State registers; asynchronous reset drops the slave cycle immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IW'(N_MST - 1);
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_data_arbiter.sv
// tb/tb_wb_rr_data_arbiter.sv - self-checking bench for wb_rr_data_arbiter
module tb_wb_rr_data_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [31:0] RDATA = 32'hDEAD_BEEF;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic [N-1:0]    i_m_cyc = '0;
    logic [N-1:0]    i_m_we;
    logic [N*AW-1:0] i_m_adr;
    logic [N*DW-1:0] i_m_dat_w;
    logic [DW-1:0]   o_m_dat_r;
    logic [N-1:0]    o_m_ack, o_m_err;
    logic            o_s_cyc, o_s_stb, o_s_we;
    logic [AW-1:0]   o_s_adr;
    logic [DW-1:0]   o_s_dat_w;
    logic [DW-1:0]   i_s_dat_r = RDATA;
    logic            i_s_ack = 1'b0;
    logic [N-1:0]    o_grant;
    logic            o_busy;

    logic [31:0] adr_tab [N];
    logic [31:0] dat_tab [N];
    logic        we_tab  [N];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] cyc;
        logic         ack;
        logic [N-1:0] grant;
        logic         busy;
        logic         stb;
        logic [N-1:0] mack;
        logic [N-1:0] merr;
    } vec_t;

    vec_t vecs[$];

    wb_rr_data_arbiter #(.N_MST(N), .DW(DW), .AW(AW), .TIMEOUT(4), .TW(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m_cyc(i_m_cyc), .i_m_we(i_m_we), .i_m_adr(i_m_adr), .i_m_dat_w(i_m_dat_w),
        .o_m_dat_r(o_m_dat_r), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_adr(o_s_adr), .o_s_dat_w(o_s_dat_w), .i_s_dat_r(i_s_dat_r), .i_s_ack(i_s_ack),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d got 0x%0h want 0x%0h", nm, vi, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [N-1:0] cyc, input logic ack,
                       input logic [N-1:0] grant, input logic busy, input logic stb,
                       input logic [N-1:0] mack, input logic [N-1:0] merr);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.grant = grant;
        v.busy = busy; v.stb = stb; v.mack = mack; v.merr = merr;
        vecs.push_back(v);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        int gi;
        int n;
        adr_tab[0] = 32'h100; adr_tab[1] = 32'h10; adr_tab[2] = 32'h200;
        dat_tab[0] = 32'h11;  dat_tab[1] = 32'hAB; dat_tab[2] = 32'h22;
        we_tab[0]  = 1'b0;    we_tab[1]  = 1'b1;   we_tab[2]  = 1'b0;
        for (int i = 0; i < N; i++) begin
            i_m_adr[i*AW +: AW]   = adr_tab[i];
            i_m_dat_w[i*DW +: DW] = dat_tab[i];
            i_m_we[i]             = we_tab[i];
        end

        //   rst cyc     ack grant  busy stb mack    merr
        add(0, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b000); // held in reset
        add(1, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b000); // reset state
        add(1, 3'b010, 0, 3'b000, 0, 0, 3'b000, 3'b000); // m1 write request seen
        add(1, 3'b010, 0, 3'b010, 1, 1, 3'b000, 3'b000);
        add(1, 3'b010, 1, 3'b010, 1, 1, 3'b010, 3'b000);
        add(1, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(0, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000); // reset, then rotation
        add(1, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b111, 1, 3'b001, 1, 1, 3'b001, 3'b000);
        add(1, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b111, 1, 3'b010, 1, 1, 3'b010, 3'b000);
        add(1, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b111, 1, 3'b100, 1, 1, 3'b100, 3'b000);
        add(1, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b111, 1, 3'b001, 1, 1, 3'b001, 3'b000);
        add(1, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b000, 0, 0, 3'b000, 3'b000); // m2 read, no ack
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b100); // watchdog fires
        add(1, 3'b100, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 0, 3'b100, 1, 1, 3'b000, 3'b000);
        add(1, 3'b100, 1, 3'b100, 1, 1, 3'b100, 3'b000); // ack beats timeout
        add(1, 3'b000, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b011, 0, 3'b000, 0, 0, 3'b000, 3'b000); // m0 abort, m1 pending
        add(1, 3'b011, 0, 3'b001, 1, 1, 3'b000, 3'b000);
        add(1, 3'b010, 1, 3'b001, 1, 0, 3'b000, 3'b000); // late ack ignored
        add(1, 3'b010, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b010, 0, 3'b010, 1, 1, 3'b000, 3'b000);
        add(0, 3'b111, 1, 3'b000, 0, 0, 3'b000, 3'b000); // reset mid-BUSY
        add(1, 3'b111, 0, 3'b000, 0, 0, 3'b000, 3'b000);
        add(1, 3'b111, 1, 3'b001, 1, 1, 3'b001, 3'b000);

        repeat (2) @(posedge i_clk);
        #1;
        foreach (vecs[vi]) begin
            i_rst   = vecs[vi].rst;
            i_m_cyc = vecs[vi].cyc;
            i_s_ack = vecs[vi].ack;
            #4;
            chk("grant", vi, 32'(o_grant), 32'(vecs[vi].grant));
            chk("busy",  vi, 32'(o_busy),  32'(vecs[vi].busy));
            chk("s_stb", vi, 32'(o_s_stb), 32'(vecs[vi].stb));
            chk("s_cyc", vi, 32'(o_s_cyc), 32'(vecs[vi].stb));
            chk("m_ack", vi, 32'(o_m_ack), 32'(vecs[vi].mack));
            chk("m_err", vi, 32'(o_m_err), 32'(vecs[vi].merr));
            chk("m_dat_r", vi, o_m_dat_r, vecs[vi].busy ? RDATA : 32'h0);
            if (vecs[vi].busy) begin
                gi = onehot_idx(vecs[vi].grant);
                chk("s_adr",   vi, o_s_adr,      adr_tab[gi]);
                chk("s_dat_w", vi, o_s_dat_w,    dat_tab[gi]);
                chk("s_we",    vi, 32'(o_s_we),  32'(we_tab[gi]));
            end
            @(posedge i_clk);
            #1;
        end

        // Request-to-strobe latency with a bounded wait, then a read completion.
        i_m_cyc = 3'b100;
        i_s_ack = 1'b0;
        n = 0;
        #1;
        while (!o_s_stb && n < 8) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("stb_latency", 100, 32'(n), 32'd1);
        i_s_ack = 1'b1;
        #1;
        chk("rd_ack",   101, 32'(o_m_ack), 32'b100);
        chk("rd_data",  101, o_m_dat_r,    RDATA);
        chk("rd_adr",   101, o_s_adr,      32'h200);
        @(posedge i_clk);
        #1;
        i_m_cyc = '0;
        i_s_ack = 1'b0;
        #1;
        chk("rd_idle",  102, 32'(o_grant), 32'b000);
        chk("rd_noack", 102, 32'(o_m_ack), 32'b000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
